// File: rtl/fetch_controller_if.sv
// fetch_controller_if: run/stall/redirect control, instruction-memory handshake and fetch outputs.
interface fetch_controller_if;
   logic        run;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [31:0] pc;
   logic [31:0] fetch_count;
   logic        error;
   modport master (
      input  run, stall, redirect, redirect_addr, mem_ack, mem_rdata,
      output mem_req, mem_addr, inst_valid, inst, inst_pc, pc, fetch_count, error
   );
   modport slave (
      output run, stall, redirect, redirect_addr, mem_ack, mem_rdata,
      input  mem_req, mem_addr, inst_valid, inst, inst_pc, pc, fetch_count, error
   );
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: single-outstanding instruction fetcher with stall hold, redirect and
// a sticky error trap for misaligned redirect targets.
module fetch_controller #(
   parameter logic [31:0] RESET_PC = 32'h00400020
) (
   input logic clock,
   input logic reset_n,
   fetch_controller_if.master bus
);
   typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERROR} state_t;
   state_t      state;
   logic [31:0] pc;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [31:0] fetch_count;
   logic        mem_req;
   logic        inst_valid;
   logic        error;
   logic        misaligned;
   assign misaligned = |bus.redirect_addr[1:0];
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         inst        <= '0;
         inst_pc     <= '0;
         fetch_count <= '0;
         mem_req     <= 1'b0;
         inst_valid  <= 1'b0;
         error       <= 1'b0;
      end else if (state != ERROR) begin
         if (bus.redirect && misaligned) begin
            state      <= ERROR;
            error      <= 1'b1;
            mem_req    <= 1'b0;
            inst_valid <= 1'b0;
         end else if (bus.redirect) begin
            // A redirect mid-FETCH keeps the request up and simply retargets it.
            pc <= bus.redirect_addr;
            if (state != FETCH) begin
               inst_valid <= 1'b0;
               mem_req    <= bus.run;
               state      <= bus.run ? FETCH : IDLE;
            end
         end else begin
            case (state)
               IDLE: if (bus.run) begin
                  state   <= FETCH;
                  mem_req <= 1'b1;
               end
               FETCH: if (bus.mem_ack) begin
                  inst        <= bus.mem_rdata;
                  inst_pc     <= pc;
                  pc          <= pc + 32'd4;
                  fetch_count <= fetch_count + 32'd1;
                  mem_req     <= 1'b0;
                  inst_valid  <= 1'b1;
                  state       <= HOLD;
               end
               HOLD: if (!bus.stall) begin
                  inst_valid <= 1'b0;
                  mem_req    <= bus.run;
                  state      <= bus.run ? FETCH : IDLE;
               end
               default: ;
            endcase
         end
      end
   end
   assign bus.pc          = pc;
   assign bus.mem_addr    = pc;
   assign bus.mem_req     = mem_req;
   assign bus.inst_valid  = inst_valid;
   assign bus.inst        = inst;
   assign bus.inst_pc     = inst_pc;
   assign bus.fetch_count = fetch_count;
   assign bus.error       = error;
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed literal checks plus randomized traffic compared every cycle
// against a behavioural fetch model.
module tb_fetch_controller;
   localparam logic [31:0] RST_PC = 32'h00400020;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   bit   chk_en = 1'b0;
   fetch_controller_if bus();
   fetch_controller #(.RESET_PC(RST_PC)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
   always #5 clock = ~clock;

   // Behavioural model: outstanding-request flag, held-instruction flag, trap flag.
   bit          m_req = 0, m_hold = 0, m_err = 0;
   logic [31:0] m_pc = RST_PC, m_inst = '0, m_ipc = '0, m_cnt = '0;

   always @(posedge clock) begin
      if (!reset_n) begin
         m_req = 0; m_hold = 0; m_err = 0;
         m_pc = RST_PC; m_inst = '0; m_ipc = '0; m_cnt = '0;
      end else if (m_err) begin
      end else if (bus.redirect) begin
         if (bus.redirect_addr[1:0] != 2'b00) begin
            m_err = 1; m_req = 0; m_hold = 0;
         end else begin
            m_pc = bus.redirect_addr;
            if (!m_req) begin
               m_hold = 0;
               m_req  = bus.run;
            end
         end
      end else if (m_req) begin
         if (bus.mem_ack) begin
            m_inst = bus.mem_rdata; m_ipc = m_pc; m_pc = m_pc + 4; m_cnt = m_cnt + 1;
            m_req = 0; m_hold = 1;
         end
      end else if (m_hold) begin
         if (!bus.stall) begin
            m_hold = 0;
            m_req  = bus.run;
         end
      end else begin
         m_req = bus.run;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         chk("mem_req", {31'd0, bus.mem_req}, {31'd0, m_req});
         chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, m_hold});
         chk("error", {31'd0, bus.error}, {31'd0, m_err});
         chk("pc", bus.pc, m_pc);
         chk("fetch_count", bus.fetch_count, m_cnt);
         if (m_req) chk("mem_addr", bus.mem_addr, m_pc);
         if (m_hold) begin
            chk("inst", bus.inst, m_inst);
            chk("inst_pc", bus.inst_pc, m_ipc);
         end
      end
   end

   task automatic step(input logic rn, input logic r, input logic st, input logic rd,
                       input logic [31:0] ra, input logic ack, input logic [31:0] d);
      @(negedge clock);
      #1;
      reset_n = rn; bus.run = r; bus.stall = st; bus.redirect = rd;
      bus.redirect_addr = ra; bus.mem_ack = ack; bus.mem_rdata = d;
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [31:0] ra;
      bus.run = 0; bus.stall = 0; bus.redirect = 0; bus.redirect_addr = '0;
      bus.mem_ack = 0; bus.mem_rdata = '0;
      step(0, 0, 0, 0, 0, 0, 0);
      chk_en = 1;
      chk("rst pc", bus.pc, RST_PC);
      chk("rst mem_addr", bus.mem_addr, RST_PC);
      chk("rst inst", bus.inst, 32'h0);
      chk("rst inst_pc", bus.inst_pc, 32'h0);
      step(1, 0, 0, 0, 0, 1, 32'h11);
      step(1, 0, 0, 0, 0, 1, 32'h22);
      chk("idle mem_req", {31'd0, bus.mem_req}, 32'd0);
      chk("idle count", bus.fetch_count, 32'd0);
      // back-to-back fetches with immediate ack
      for (int k = 0; k < 3; k++) begin
         step(1, 1, 0, 0, 0, 0, 0);
         chk("seq mem_req", {31'd0, bus.mem_req}, 32'd1);
         chk("seq mem_addr", bus.mem_addr, RST_PC + 32'(4 * k));
         step(1, 1, 0, 0, 0, 1, 32'hA0000000 + 32'(k));
         chk("seq inst_valid", {31'd0, bus.inst_valid}, 32'd1);
         chk("seq inst", bus.inst, 32'hA0000000 + 32'(k));
         chk("seq count", bus.fetch_count, 32'(k + 1));
      end
      // stall holds the delivered instruction
      for (int k = 0; k < 5; k++) begin
         step(1, 1, 1, 0, 0, 1, 32'h5555);
         chk("stall inst", bus.inst, 32'hA0000002);
         chk("stall mem_req", {31'd0, bus.mem_req}, 32'd0);
      end
      step(1, 1, 0, 0, 0, 0, 0);
      chk("unstall mem_addr", bus.mem_addr, 32'h0040002C);
      // delayed ack keeps the request stable
      for (int k = 0; k < 3; k++) begin
         step(1, 0, 0, 0, 0, 0, 32'h77);
         chk("wait mem_req", {31'd0, bus.mem_req}, 32'd1);
         chk("wait mem_addr", bus.mem_addr, 32'h0040002C);
      end
      step(1, 0, 0, 0, 0, 1, 32'hDEADBEEF);
      chk("late inst", bus.inst, 32'hDEADBEEF);
      chk("late inst_pc", bus.inst_pc, 32'h0040002C);
      step(1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 1, 32'h00400100, 1, 32'hBAD0BAD0);
      chk("redir count", bus.fetch_count, 32'd4);
      chk("redir mem_addr", bus.mem_addr, 32'h00400100);
      chk("redir inst_valid", {31'd0, bus.inst_valid}, 32'd0);
      step(1, 1, 0, 1, 32'h00400102, 0, 0);
      chk("misalign error", {31'd0, bus.error}, 32'd1);
      chk("misalign pc", bus.pc, 32'h00400100);
      for (int k = 0; k < 3; k++) begin
         step(1, 1, 0, 0, 0, 1, 32'h99);
         chk("trap mem_req", {31'd0, bus.mem_req}, 32'd0);
      end
      // pc wrap, then reset in the middle of a request
      step(0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 1, 32'hFFFFFFFC, 0, 0);
      chk("wrap mem_addr", bus.mem_addr, 32'hFFFFFFFC);
      step(1, 1, 0, 0, 0, 1, 32'h12345678);
      chk("wrap pc", bus.pc, 32'h00000000);
      chk("wrap inst_pc", bus.inst_pc, 32'hFFFFFFFC);
      step(1, 1, 0, 0, 0, 0, 0);
      chk("wrap fetch", bus.mem_addr, 32'h00000000);
      step(0, 1, 0, 0, 0, 1, 32'h66);
      chk("midreset pc", bus.pc, RST_PC);
      chk("midreset mem_req", {31'd0, bus.mem_req}, 32'd0);
      chk("midreset count", bus.fetch_count, 32'd0);
      for (int n = 0; n < 4000; n++) begin
         ra = $urandom;
         ra = ($urandom_range(0, 9) == 0) ? ra : {ra[31:2], 2'b00};
         if ($urandom_range(0, 19) == 0) ra = 32'hFFFFFFF8;
         step($urandom_range(0, 63) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 15) == 0, ra, $urandom_range(0, 2) != 0, $urandom);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h00400020, SHALL be the PC loaded at reset.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising clock edge.
REQ-004 run  input  1  fetch enable.
REQ-005 stall  input  1  downstream not ready; instruction consumed when inst_valid=1 and stall=0.
REQ-006 redirect  input  1  load redirect_addr into PC (branch/jump).
REQ-007 redirect_addr  input  32  redirect target.
REQ-008 mem_req  output  1  instruction memory request.
REQ-009 mem_addr  output  32  byte address of request.
REQ-010 mem_ack  input  1  memory returns mem_rdata this cycle.
REQ-011 mem_rdata  input  32  instruction word.
REQ-012 inst_valid  output  1  inst/inst_pc valid.
REQ-013 inst  output  32  fetched instruction.
REQ-014 inst_pc  output  32  address of inst.
REQ-015 pc  output  32  next address to fetch.
REQ-016 fetch_count  output  32  instructions delivered since reset.
REQ-017 error  output  1  sticky misaligned-redirect flag.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, HOLD, ERROR.
REQ-019 IDLE: mem_req=0, inst_valid=0; run=1 -> FETCH next cycle.
REQ-020 FETCH: mem_req=1, mem_addr=pc, both held stable until mem_ack=1.
REQ-021 FETCH with mem_ack=1 and redirect=0: inst<=mem_rdata, inst_pc<=pc, pc<=pc+4 (mod 2^32, 32'hFFFFFFFC wraps to 0), fetch_count+1 (wraps), -> HOLD.
REQ-022 HOLD: inst_valid=1, mem_req=0, inst/inst_pc stable; stall=0 -> FETCH if run=1 else IDLE; stall=1 -> stay.
REQ-023 Latency: run asserted in IDLE at cycle t, mem_ack at t+1 -> mem_req at t+1, inst_valid at t+2.
REQ-024 run deasserted in FETCH SHALL NOT abandon the request; it completes to HOLD.
REQ-025 redirect=1 with redirect_addr[1:0]=0, any non-ERROR state: pc<=redirect_addr; redirect outranks stall and mem_ack.
REQ-026 Redirect in FETCH: mem_rdata of that cycle discarded (no count), state stays FETCH, mem_addr=redirect_addr next cycle.
REQ-027 Redirect in HOLD: held instruction squashed, inst_valid=0 next cycle, -> FETCH if run=1 else IDLE; squashed instruction stays counted.
REQ-028 Redirect in IDLE: pc updated, state -> FETCH only if run=1.
REQ-029 redirect=1 with redirect_addr[1:0]!=0: -> ERROR, error=1, pc unchanged, mem_req=0, inst_valid=0; ERROR exits only by reset.

Reset
REQ-030 reset_n=0 at a rising edge SHALL force state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fetch_count=0, error=0, from any state including mid-FETCH (request dropped, late mem_ack ignored).
REQ-031 After release all outputs SHALL hold reset values until run=1.

Verification
REQ-032 Reset, run=1, mem_ack=1 always, stall=0 -> mem_addr 00400020, 00400024, 00400028 on alternate cycles; inst_valid every 2nd cycle; fetch_count 3 after 3 deliveries.
REQ-033 mem_ack delayed 3 cycles -> mem_req/mem_addr=00400020 stable 4 cycles; inst=mem_rdata, inst_pc=00400020 next cycle.
REQ-034 HOLD with stall=1 for 5 cycles -> inst_valid/inst constant, no mem_req; stall=0 -> FETCH 00400024.
REQ-035 redirect to 00400100 coincident with mem_ack -> data dropped, fetch_count unchanged, next mem_addr=00400100; redirect to 00400102 -> error=1, mem_req=0 until reset.
REQ-036 pc=FFFFFFFC fetched -> pc=00000000; reset_n=0 mid-FETCH -> pc=00400020, mem_req=0 next cycle.
